mag_sr_cmd_gen: RTL and testbench
=================================

# mag_sr_cmd_gen

Synchronous command generator that drives the S/R inputs of the magnetron SR latch in the Mag_Control path. It turns raw START/STOP buttons plus DOOR_CLOSED and TIMER_DONE levels into clean, non-overlapping, fixed-width S and R pulses. It keeps a shadow of the latch state so the controller knows whether the magnetron is commanded on. It sits between the panel/timer logic and the SR latch.

## Interface
- DEB_CYCLES, 4: consecutive stable cycles required before a button level is accepted (≥1).
- PULSE_W, 2: width in clock cycles of every S or R pulse (≥1).

- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  raw start button, active-high, asynchronous to CLK.
- STOP  in  1  raw stop/cancel button, active-high, asynchronous.
- DOOR_CLOSED  in  1  door switch level, 1 = closed, asynchronous.
- TIMER_DONE  in  1  cook timer expired level, asynchronous.
- S  out  1  set pulse to SR latch.
- R  out  1  reset pulse to SR latch.
- MAG_ON  out  1  shadow latch state, 1 only in RUN.
- BUSY  out  1  S or R pulse in progress.

## Operation
- All four inputs pass through a 2-FF synchronizer. DOOR_CLOSED and TIMER_DONE are used as levels after the synchronizer.
- START and STOP are debounced: a new level is accepted only after DEB_CYCLES consecutive equal synchronized samples. Each debounce counter restarts on any change.
- A rising edge of the accepted level produces a one-cycle event (start_evt / stop_evt). Falling edges produce no event.
- FSM states: IDLE, RUN, HOLD.
- IDLE: on start_evt with door closed and timer not done, issue S and go to RUN. Otherwise stay in IDLE.
- RUN: on stop_evt or TIMER_DONE, issue R and go to IDLE. Otherwise, on door open, issue R and go to HOLD. Stop/timer has priority over door.
- HOLD: on stop_evt or TIMER_DONE, go to IDLE with no pulse, since the latch is already reset. On start_evt with door closed, issue S and go to RUN.
- Pulse unit: a request loads a counter with PULSE_W. The output stays high while the counter is nonzero. BUSY = S | R.
- An R request during an S pulse aborts the S pulse. S falls and R rises on the same edge, with no overlap cycle.
- An S request during an R pulse is dropped. The FSM does not change state for that request.
- S and R are never high in the same cycle, under any input combination.
- MAG_ON is registered: 1 in RUN, 0 in IDLE and HOLD.

## Timing
- Every edge with RST_N=0 sets: state IDLE, S=0, R=1, pulse counter=PULSE_W, MAG_ON=0, BUSY=1, debounce counters=0, accepted levels=0, synchronizers=0.
- After RST_N rises, R stays high for exactly PULSE_W more cycles, then falls. This forces the latch off at power-up.
- Reset asserted mid-pulse or mid-RUN applies on the next edge: any S drops immediately and R rises.
- START latency (macro defined): S rises on the (3+DEB_CYCLES)th edge after the first edge that samples START high, provided START is held stable.
- Door-open latency: R rises on the 3rd edge after the first edge sampling DOOR_CLOSED=0.
- TIMER_DONE latency: also 3 edges.
- START and STOP accepted on the same cycle: stop_evt wins. In IDLE the start is ignored.
- A press shorter than DEB_CYCLES cycles produces no event.

## Configuration
- Macro: MAG_SR_DEBOUNCE_EN.
- Defined: the DEB_CYCLES debounce stage is present on START and STOP, as described above.
- Undefined: no debounce. The accepted level is the synchronizer output, and DEB_CYCLES is ignored. START latency becomes 3 edges, and every synchronized rising edge is an event.

## Test plan
- Reset: hold RST_N=0 for 3 cycles, then release → S=0 throughout; R=1 during reset and for exactly PULSE_W=2 cycles after; MAG_ON=0.
- Normal cook: DOOR_CLOSED=1, START high for 10 cycles → S high for 2 cycles starting 7 edges after START (DEB_CYCLES=4); MAG_ON=1; later TIMER_DONE=1 → R for 2 cycles; MAG_ON=0.
- Bounce: START toggled every 2 cycles for 12 cycles, then low → no S pulse, MAG_ON stays 0.
- Door open in RUN: drop DOOR_CLOSED → R pulse, HOLD, MAG_ON=0. Close door and press START → S pulse, RUN. Press STOP in HOLD → IDLE with no pulse.
- Overlap: TIMER_DONE rises during S pulse → S falls and R rises on the same edge, and S&R is never 1. START and STOP accepted together in IDLE → no pulse.
- Without MAG_SR_DEBOUNCE_EN: a single-cycle START pulse with door closed → S rises 3 edges later.

Source files
------------

// File: rtl/mag_sr_cmd_gen.sv
// S/R pulse command generator for the magnetron latch: sync, optional debounce, FSM, pulse unit.
// Optional START/STOP debounce is enabled by defining MAG_SR_DEBOUNCE_EN.
module mag_sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_stop,
    input  logic i_door_closed,
    input  logic i_timer_done,
    output logic o_s,
    output logic o_r,
    output logic o_mag_on,
    output logic o_busy
);
    localparam int CNT_W = $clog2(PULSE_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

    if (DEB_CYCLES < 1 || PULSE_W < 1) begin : g_param_chk
        $error("DEB_CYCLES and PULSE_W must be >= 1");
    end

    // Bit order: {timer_done, door_closed, stop, start}
    logic [3:0] r_sync1, r_sync2;
    logic [1:0] w_lvl;
    logic [1:0] r_lvl_d;
    logic       w_start_evt, w_stop_evt, w_door, w_timer;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_timer_done, i_door_closed, i_stop, i_start};
            r_sync2 <= r_sync1;
        end
    end

`ifdef MAG_SR_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    logic [1:0][DCW-1:0] r_deb_cnt;
    logic [1:0]          r_acc;

    // Count consecutive samples that differ from the accepted level; any return resets.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_deb_cnt <= '0;
            r_acc     <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_acc[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    r_acc[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_acc;
`else
    assign w_lvl = r_sync2[1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_lvl_d <= '0;
        else          r_lvl_d <= w_lvl;
    end

    assign w_start_evt = w_lvl[0] & ~r_lvl_d[0];
    assign w_stop_evt  = w_lvl[1] & ~r_lvl_d[1];
    assign w_door      = r_sync2[2];
    assign w_timer     = r_sync2[3];

    state_t           r_state;
    logic             r_s, r_r, r_mag_on;
    logic [CNT_W-1:0] r_pcnt;

    // FSM and pulse unit share one block so a request loads the counter on the deciding edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_s      <= 1'b0;
            r_r      <= 1'b1;
            r_pcnt   <= CNT_W'(PULSE_W);
            r_mag_on <= 1'b0;
        end else begin
            if (r_pcnt != '0) begin
                r_pcnt <= r_pcnt - 1'b1;
                if (r_pcnt == CNT_W'(1)) begin
                    r_s <= 1'b0;
                    r_r <= 1'b0;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_evt && !w_stop_evt && w_door && !w_timer && !r_r) begin
                        r_state  <= ST_RUN;
                        r_mag_on <= 1'b1;
                        r_s      <= 1'b1;
                        r_pcnt   <= CNT_W'(PULSE_W);
                    end
                end
                ST_RUN: begin
                    if (w_stop_evt || w_timer || !w_door) begin
                        r_state  <= (w_stop_evt || w_timer) ? ST_IDLE : ST_HOLD;
                        r_mag_on <= 1'b0;
                        r_s      <= 1'b0;
                        r_r      <= 1'b1;
                        r_pcnt   <= CNT_W'(PULSE_W);
                    end
                end
                ST_HOLD: begin
                    if (w_stop_evt || w_timer) begin
                        r_state <= ST_IDLE;
                    end else if (w_start_evt && w_door && !r_r) begin
                        r_state  <= ST_RUN;
                        r_mag_on <= 1'b1;
                        r_s      <= 1'b1;
                        r_pcnt   <= CNT_W'(PULSE_W);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_s      = r_s;
    assign o_r      = r_r;
    assign o_mag_on = r_mag_on;
    assign o_busy   = r_s | r_r;

endmodule

// File: tb/tb_mag_sr_cmd_gen.sv
// Directed self-checking bench for mag_sr_cmd_gen; expectations follow the debounce macro setting.
module tb_mag_sr_cmd_gen;
    localparam int DEB = 4;
    localparam int PW  = 2;
`ifdef MAG_SR_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n, start, stop, door, timer;
    logic o_s, o_r, o_mag_on, o_busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mag_sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_W(PW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_door_closed(door), .i_timer_done(timer),
        .o_s(o_s), .o_r(o_r), .o_mag_on(o_mag_on), .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Tick n cycles and require that neither S nor R pulses anywhere in the window.
    task automatic watch(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | o_s | o_r;
        end
        chk(tag, seen, 1'b0);
    endtask

    always @(negedge clk) chk("s_r_overlap", o_s & o_r, 1'b0);

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; door = 1'b0; timer = 1'b0;

        // Reset and power-up R pulse
        repeat (3) tick();
        chk("rst_s", o_s, 1'b0);
        chk("rst_r", o_r, 1'b1);
        chk("rst_busy", o_busy, 1'b1);
        chk("rst_mag", o_mag_on, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("pwrup_r_hold", o_r, 1'b1);
        tick();
        chk("pwrup_r_fall", o_r, 1'b0);
        chk("pwrup_busy_fall", o_busy, 1'b0);

        // Normal cook
        door = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        repeat (LAT - 1) tick();
        chk("cook_s_early", o_s, 1'b0);
        tick();
        chk("cook_s_rise", o_s, 1'b1);
        chk("cook_mag_on", o_mag_on, 1'b1);
        chk("cook_busy", o_busy, 1'b1);
        tick();
        chk("cook_s_2nd", o_s, 1'b1);
        tick();
        chk("cook_s_fall", o_s, 1'b0);
        repeat (10 - (LAT + 2)) tick();
        start = 1'b0;
        repeat (DEB + 4) tick();
        chk("cook_release_mag", o_mag_on, 1'b1);
        timer = 1'b1;
        repeat (2) tick();
        chk("timer_r_early", o_r, 1'b0);
        tick();
        chk("timer_r_rise", o_r, 1'b1);
        chk("timer_mag_off", o_mag_on, 1'b0);
        tick();
        chk("timer_r_2nd", o_r, 1'b1);
        tick();
        chk("timer_r_fall", o_r, 1'b0);
        timer = 1'b0;
        repeat (4) tick();

        // Single-cycle START press
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
`ifdef MAG_SR_DEBOUNCE_EN
        chk("short_press_s", o_s, 1'b0);
        watch(DEB + 4, "short_press_quiet");
        chk("short_press_mag", o_mag_on, 1'b0);

        // Bouncing START
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                start = ((i / 2) % 2 == 0);
                tick();
                seen = seen | o_s;
            end
            start = 1'b0;
            chk("bounce_no_s", seen, 1'b0);
        end
        watch(DEB + 4, "bounce_quiet");
        chk("bounce_mag", o_mag_on, 1'b0);
`else
        chk("short_press_s", o_s, 1'b1);
        chk("short_press_mag", o_mag_on, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        chk("short_stop_r", o_r, 1'b1);
        chk("short_stop_mag", o_mag_on, 1'b0);
        repeat (3) tick();
`endif

        // Door opens during RUN, restart from HOLD, then STOP in HOLD
        start = 1'b1;
        repeat (LAT + 2) tick();
        chk("run2_mag", o_mag_on, 1'b1);
        start = 1'b0;
        repeat (DEB + 3) tick();
        door = 1'b0;
        repeat (2) tick();
        chk("door_r_early", o_r, 1'b0);
        tick();
        chk("door_r_rise", o_r, 1'b1);
        chk("door_mag_off", o_mag_on, 1'b0);
        repeat (2) tick();
        chk("door_r_fall", o_r, 1'b0);
        door = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        repeat (LAT) tick();
        chk("hold_restart_s", o_s, 1'b1);
        chk("hold_restart_mag", o_mag_on, 1'b1);
        start = 1'b0;
        repeat (DEB + 3) tick();
        door = 1'b0;
        repeat (5) tick();
        chk("hold2_mag", o_mag_on, 1'b0);
        stop = 1'b1;
        watch(LAT + 3, "hold_stop_nopulse");
        chk("hold_stop_mag", o_mag_on, 1'b0);
        stop = 1'b0;
        door = 1'b1;
        repeat (DEB + 3) tick();

        // TIMER_DONE arrives during the S pulse
        start = 1'b1;
        repeat (LAT - 2) tick();
        timer = 1'b1;
        repeat (2) tick();
        chk("ovl_s_rise", o_s, 1'b1);
        chk("ovl_r_low", o_r, 1'b0);
        tick();
        chk("ovl_s_abort", o_s, 1'b0);
        chk("ovl_r_rise", o_r, 1'b1);
        chk("ovl_mag_off", o_mag_on, 1'b0);
        repeat (2) tick();
        chk("ovl_r_fall", o_r, 1'b0);
        start = 1'b0;
        timer = 1'b0;
        repeat (DEB + 3) tick();

        // START and STOP accepted together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        watch(LAT + 3, "both_no_pulse");
        chk("both_mag", o_mag_on, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        repeat (DEB + 3) tick();

        // Reset during an S pulse
        start = 1'b1;
        repeat (LAT) tick();
        chk("midrst_s_before", o_s, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midrst_s_drop", o_s, 1'b0);
        chk("midrst_r_rise", o_r, 1'b1);
        chk("midrst_mag", o_mag_on, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("midrst_r_hold", o_r, 1'b1);
        tick();
        chk("midrst_r_fall", o_r, 1'b0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
